beam_rank_reader: RTL
=====================

BEAM_RANK_READER -- requirements
Module: beam_rank_reader

Interface
REQ-001 SHALL take parameter IW, default 32: beam data width.
REQ-002 SHALL take parameter COL, default 64: beams per frame.
REQ-003 SHALL take parameter K, default 16: number of lowest-rank beams emitted per frame (1..COL).
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port i_data  input  [COL-1:0][IW-1:0]  per-column beam data from the sorter.
REQ-007 SHALL have port i_score  input  [COL-1:0][7:0]  per-column rank; 0 means smallest.
REQ-008 SHALL have port i_tvalid  input  1  frame valid from the sorter.
REQ-009 SHALL have port o_tready  output  1  frame accept back to the sorter.
REQ-010 SHALL have port o_data  output  IW  data of the beam in the current rank slot.
REQ-011 SHALL have port o_index  output  8  column index of that beam; 8'hFF marks an empty slot.
REQ-012 SHALL have port o_rank  output  8  rank slot number, 0..K-1.
REQ-013 SHALL have port o_valid  output  1  output beat valid.
REQ-014 SHALL have port i_ready  input  1  downstream accept.
REQ-015 SHALL have port o_last  output  1  high on beat K-1.
REQ-016 SHALL have port o_err  output  1  sticky flag for a rank collision or missing rank.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD and STREAM.
REQ-018 o_tready SHALL be 1 in IDLE only and 0 in LOAD and STREAM; there is no second frame buffer.
REQ-019 In IDLE, a cycle with i_tvalid && o_tready SHALL capture the frame into a K-entry slot table: slot[i_score[c]] = {c, i_data[c]} for every c with i_score[c] < K; the FSM then goes to LOAD.
REQ-020 Columns with i_score >= K SHALL be discarded without error.
REQ-021 When two or more columns carry the same rank, the lowest column index SHALL win the slot and o_err SHALL be set.
REQ-022 In LOAD (exactly one cycle), any slot left without a writer SHALL be marked empty (o_index 8'hFF, o_data 0) and o_err SHALL be set; the FSM then goes to STREAM.
REQ-023 In STREAM, o_valid SHALL be 1, and a beat counter starting at 0 SHALL drive o_rank and select slot[counter] onto o_index and o_data.
REQ-024 The counter SHALL advance only on o_valid && i_ready.
REQ-025 o_data, o_index, o_rank and o_last SHALL stay stable while o_valid && !i_ready.
REQ-026 o_last SHALL equal (counter == K-1) while o_valid is 1.
REQ-027 The handshake on the last beat SHALL return the FSM to IDLE, with o_valid 0 and o_tready 1 on the next cycle.
REQ-028 Latency: the first o_valid SHALL occur 2 cycles after the accepting edge (capture, then LOAD).
REQ-029 Exactly K beats SHALL be emitted per accepted frame, in rank order 0..K-1.
REQ-030 o_err SHALL be sticky across frames and cleared only by reset.
REQ-031 The rank comparison SHALL use all 8 score bits; no modulo or truncation is allowed.

Reset
REQ-032 While i_reset = 0 at a clock edge, the FSM SHALL go to IDLE and the counter and o_err SHALL clear to 0.
REQ-033 During reset, o_valid, o_last, o_rank and o_data SHALL be 0, o_index SHALL be 0, and o_tready SHALL be 0.
REQ-034 o_tready SHALL rise on the first cycle after reset is released.
REQ-035 A reset during LOAD or STREAM SHALL abort the frame with no further beats emitted; the slot table need not be cleared.

Structure
REQ-036 Package beam_sort_pkg SHALL hold IW, COL, K, the slot_t typedef {idx[7:0], data[IW-1:0]}, the FSM state enum and the constant EMPTY_IDX = 8'hFF.
REQ-037 One sub-module, beam_rank_scatter, SHALL provide the combinational rank-to-slot scatter with lowest-index priority and collision/fill flags; everything else stays in beam_rank_reader.

Verification
REQ-038 Identity frame, i_score[c]=c and i_data[c]=32'h100+c, i_ready=1 -> 16 beats with o_index 0..15, o_data 32'h100..32'h10F, o_last on beat 15, o_err=0.
REQ-039 Reverse frame, i_score[c]=63-c -> beat 0 has o_index 63, beat 15 has o_index 48, o_err=0.
REQ-040 Identity frame with i_ready toggling 1,0,1,0... -> 16 unique beats in order, each held unchanged through its stall cycle, 31 cycles from the first o_valid to the final handshake.
REQ-041 Identity frame but i_score[5]=0 -> beat 0 has o_index 0, beat 5 has o_index 8'hFF and o_data 0, o_err=1 and still 1 after the next clean frame.
REQ-042 Reset pulsed after 4 beats -> o_valid=0 during reset and o_tready=1 afterwards; the next identity frame restarts at o_rank 0.
REQ-043 i_tvalid held high throughout STREAM -> o_tready stays 0 until the cycle after the last handshake, then the second frame is accepted.

Source files
------------

// File: rtl/beam_sort_pkg.sv
// Shared types and constants for the beam rank reader.
// Default geometry, slot layout and FSM encoding.
package beam_sort_pkg;

   localparam int IW  = 32;
   localparam int COL = 64;
   localparam int K   = 16;

   localparam logic [7:0] EMPTY_IDX = 8'hFF;

   typedef struct packed {
      logic [7:0]    idx;
      logic [IW-1:0] data;
   } slot_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } state_t;

   // True when a full 8-bit score selects rank slot k.
   function automatic logic rank_hit(
      input logic [7:0] score,
      input int unsigned k
   );
      return score == 8'(k);
   endfunction

endpackage

// File: rtl/beam_rank_scatter.sv
// Combinational rank-to-slot scatter.
// Lowest column wins a shared rank; reports fills and collisions.
module beam_rank_scatter #(
   parameter int IW  = 32,
   parameter int COL = 64,
   parameter int K   = 16
) (
   input  logic [COL-1:0][IW-1:0] i_data,
   input  logic [COL-1:0][7:0]    i_score,
   output logic [K-1:0][7:0]      o_idx,
   output logic [K-1:0][IW-1:0]   o_data,
   output logic [K-1:0]           o_fill,
   output logic                   o_coll
);

   import beam_sort_pkg::*;

   // Per slot, scan columns upward so the first hit owns the slot.
   always_comb begin
      o_idx  = '0;
      o_data = '0;
      o_fill = '0;
      o_coll = 1'b0;
      for (int k = 0; k < K; k++) begin
         o_idx[k] = EMPTY_IDX;
         for (int c = 0; c < COL; c++) begin
            if (rank_hit(i_score[c], k)) begin
               if (o_fill[k]) begin
                  o_coll = 1'b1;
               end else begin
                  o_fill[k] = 1'b1;
                  o_idx[k]  = 8'(c);
                  o_data[k] = i_data[c];
               end
            end
         end
      end
   end

endmodule

// File: rtl/beam_rank_reader.sv
// Captures one sorted frame and streams its K lowest ranks.
// Single-buffered: no new frame is taken while streaming.
module beam_rank_reader #(
   parameter int IW  = 32,
   parameter int COL = 64,
   parameter int K   = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [COL-1:0][IW-1:0] i_data,
   input  logic [COL-1:0][7:0]    i_score,
   input  logic                   i_tvalid,
   output logic                   o_tready,
   output logic [IW-1:0]          o_data,
   output logic [7:0]             o_index,
   output logic [7:0]             o_rank,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic                   o_last,
   output logic                   o_err
);

   import beam_sort_pkg::*;

   state_t state_q;
   state_t state_d;

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic       err_q;
   logic       err_d;

   logic [K-1:0][7:0]    slot_idx_q;
   logic [K-1:0][IW-1:0] slot_data_q;
   logic [K-1:0]         fill_q;

   logic [K-1:0][7:0]    sc_idx;
   logic [K-1:0][IW-1:0] sc_data;
   logic [K-1:0]         sc_fill;
   logic                 sc_coll;

   logic          accept;
   logic          beat_last;
   logic          beat_done;
   logic [7:0]    sel_idx;
   logic [IW-1:0] sel_data;

   beam_rank_scatter #(
      .IW  (IW),
      .COL (COL),
      .K   (K)
   ) u_scatter (
      .i_data  (i_data),
      .i_score (i_score),
      .o_idx   (sc_idx),
      .o_data  (sc_data),
      .o_fill  (sc_fill),
      .o_coll  (sc_coll)
   );

   // Handshake qualifiers shared by the FSM and datapath.
   always_comb begin
      accept    = i_reset && (state_q == IDLE) && i_tvalid;
      beat_last = (cnt_q == 8'(K-1));
      beat_done = (state_q == STREAM) && i_ready;
   end

   // Pick the slot addressed by the beat counter.
   always_comb begin
      sel_idx  = '0;
      sel_data = '0;
      for (int k = 0; k < K; k++) begin
         if (cnt_q == 8'(k)) begin
            sel_idx  = slot_idx_q[k];
            sel_data = slot_data_q[k];
         end
      end
   end

   // State, beat counter and sticky error register.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Slot table: scatter on capture, empty-fill on LOAD.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int k = 0; k < K; k++) begin
            if (sc_fill[k]) begin
               slot_idx_q[k]  <= sc_idx[k];
               slot_data_q[k] <= sc_data[k];
            end
         end
         fill_q <= sc_fill;
      end else if (state_q == LOAD) begin
         for (int k = 0; k < K; k++) begin
            if (!fill_q[k]) begin
               slot_idx_q[k]  <= EMPTY_IDX;
               slot_data_q[k] <= '0;
            end
         end
      end
   end

   // Next-state, counter and error update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = LOAD;
               if (sc_coll) begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            state_d = STREAM;
            cnt_d   = '0;
            if (!(&fill_q)) begin
               err_d = 1'b1;
            end
         end
         STREAM: begin
            if (beat_done) begin
               if (beat_last) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs, forced quiet while reset is asserted.
   always_comb begin
      o_tready = 1'b0;
      o_valid  = 1'b0;
      o_data   = '0;
      o_index  = '0;
      o_rank   = '0;
      o_last   = 1'b0;
      o_err    = err_q;
      if (i_reset) begin
         unique case (state_q)
            IDLE: begin
               o_tready = 1'b1;
            end
            STREAM: begin
               o_valid = 1'b1;
               o_data  = sel_data;
               o_index = sel_idx;
               o_rank  = cnt_q;
               o_last  = beat_last;
            end
            default: begin
               o_tready = 1'b0;
            end
         endcase
      end
   end

endmodule
